// File: rtl/npu_mem_responder_pkg.sv
// Shared types for the NPU scratchpad responder: FSM state encoding and
// statistics counter width.
package npu_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

  localparam int MEM_CNT_W = 32;

endpackage

// File: rtl/npu_mem_array.sv
// DEPTH x WIDTH scratchpad storage: synchronous write, registered read
// followed by an RD_LAT-1 deep shift pipeline so read data lands RD_LAT edges later.
module npu_mem_array #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2,
  parameter int AW     = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] rd_pipe [RD_LAT];

  // NOTE: storage and read pipeline carry no reset so they map onto RAM macros;
  // only the control path in the responder is reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rd_pipe[0] <= mem[addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign rdata = rd_pipe[RD_LAT-1];

endmodule

// File: rtl/npu_mem_responder.sv
// Single-outstanding scratchpad responder for the systolic NPU request port.
// Define NPU_MEM_STATS_EN to build the read/write/error statistics counters.
module npu_mem_responder
  import npu_mem_responder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic [MEM_CNT_W-1:0] reads_count,
  output logic [MEM_CNT_W-1:0] writes_count,
  output logic [MEM_CNT_W-1:0] err_count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  mem_state_t       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             pend_write;
  logic             pend_err;
  logic             accept;
  logic             in_range;
  logic             mem_we;
  logic             mem_re;
  logic [WIDTH-1:0] arr_rdata;

  assign req_ready = (state == MEM_IDLE) || (state == MEM_RESP);
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_L;
  assign mem_we    = accept && req_write && in_range && !rst;
  assign mem_re    = accept && !req_write && in_range && !rst;

  npu_mem_array #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  // The response for whatever request sits in MEM_RESP is registered on the
  // edge that leaves MEM_RESP, so a new acceptance on that edge never collides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MEM_IDLE;
      lat_cnt    <= '0;
      pend_write <= 1'b0;
      pend_err   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state == MEM_RESP);
      rsp_err   <= (state == MEM_RESP) && pend_err;
      rsp_rdata <= (state == MEM_RESP && !pend_write && !pend_err) ? arr_rdata : '0;

      if (accept) begin
        pend_write <= req_write;
        pend_err   <= !in_range;
        if (req_write || RD_LAT == 1) begin
          state <= MEM_RESP;
        end else begin
          state   <= MEM_WAIT;
          lat_cnt <= LAT_W'(RD_LAT - 1);
        end
      end else begin
        case (state)
          MEM_WAIT: begin
            lat_cnt <= lat_cnt - LAT_W'(1);
            if (lat_cnt == LAT_W'(1)) state <= MEM_RESP;
          end
          MEM_RESP: state <= MEM_IDLE;
          default:  state <= MEM_IDLE;
        endcase
      end
    end
  end

`ifdef NPU_MEM_STATS_EN
  logic [MEM_CNT_W-1:0] reads_q;
  logic [MEM_CNT_W-1:0] writes_q;
  logic [MEM_CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      reads_q  <= '0;
      writes_q <= '0;
      err_q    <= '0;
    end else if (accept) begin
      if (req_write) writes_q <= writes_q + MEM_CNT_W'(1);
      else           reads_q  <= reads_q + MEM_CNT_W'(1);
      if (!in_range) err_q    <= err_q + MEM_CNT_W'(1);
    end
  end

  assign reads_count  = reads_q;
  assign writes_count = writes_q;
  assign err_count    = err_q;
`else
  assign reads_count  = '0;
  assign writes_count = '0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_npu_mem_responder.sv
// Directed bench for npu_mem_responder: dut_a (DEPTH=64, RD_LAT=2) and
// dut_b (DEPTH=4096, RD_LAT=3); count expectations follow NPU_MEM_STATS_EN.
module tb_npu_mem_responder;

`ifdef NPU_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_write, a_ready, a_rsp_valid, a_err;
  logic [11:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [31:0] a_rc, a_wc, a_ec;

  logic        b_valid, b_write, b_ready, b_rsp_valid, b_err;
  logic [11:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [31:0] b_rc, b_wc, b_ec;

  int total = 0;
  int bad   = 0;

  npu_mem_responder #(.WIDTH(16), .ADDR_W(12), .DEPTH(64), .RD_LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err),
    .reads_count(a_rc), .writes_count(a_wc), .err_count(a_ec)
  );

  npu_mem_responder #(.WIDTH(16), .ADDR_W(12), .DEPTH(4096), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .reads_count(b_rc), .writes_count(b_wc), .err_count(b_ec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write_op(input logic [11:0] addr, input logic [15:0] data,
                            input logic exp_err, input string tag);
    int n = 0;
    a_valid = 1'b1; a_write = 1'b1; a_addr = addr; a_wdata = data;
    while (!a_ready && n < 10) begin tick(); n++; end
    check({tag, "_ready"}, 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0; a_write = 1'b0;
    tick();
    check({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'd1);
    check({tag, "_rsp_err"}, 32'(a_err), 32'(exp_err));
    check({tag, "_rsp_rdata"}, 32'(a_rdata), 32'd0);
  endtask

  task automatic a_read_op(input logic [11:0] addr, input logic [15:0] exp_data,
                           input logic exp_err, input string tag);
    int n = 0;
    a_valid = 1'b1; a_write = 1'b0; a_addr = addr;
    while (!a_ready && n < 10) begin tick(); n++; end
    check({tag, "_ready"}, 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!a_rsp_valid && n < 10);
    check({tag, "_latency"}, 32'(n), 32'd2);
    check({tag, "_rdata"}, 32'(a_rdata), 32'(exp_data));
    check({tag, "_err"}, 32'(a_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    int ready_low;
    int stray;

    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_a_counts", a_rc | a_wc | a_ec, 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);

    // Write addr 16 = -7, then read it on the very next edge
    a_valid = 1'b1; a_write = 1'b1; a_addr = 12'd16; a_wdata = 16'hFFF9;
    tick();
    check("t1_wr_rsp_early", 32'(a_rsp_valid), 32'd0);
    check("t1_ready_in_resp", 32'(a_ready), 32'd1);
    a_write = 1'b0;
    tick();
    check("t1_wr_rsp_valid", 32'(a_rsp_valid), 32'd1);
    check("t1_wr_rsp_rdata", 32'(a_rdata), 32'd0);
    check("t1_wr_rsp_err", 32'(a_err), 32'd0);
    a_valid = 1'b0;
    check("t1_ready_wait", 32'(a_ready), 32'd0);
    tick();
    check("t1_rd_rsp_early", 32'(a_rsp_valid), 32'd0);
    tick();
    check("t1_rd_rsp_valid", 32'(a_rsp_valid), 32'd1);
    check("t1_rd_rdata", 32'(a_rdata), 32'h0000FFF9);
    check("t1_rd_err", 32'(a_err), 32'd0);
    tick();
    check("t1_rsp_drop", 32'(a_rsp_valid), 32'd0);

    // Back-to-back writes 0..15 with data i*3
    rst = 1'b1; tick(); rst = 1'b0;
    pulses = 0; ready_low = 0;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; a_write = 1'b1; a_addr = 12'(i); a_wdata = 16'(i * 3);
      if (!a_ready) ready_low++;
      tick();
      if (a_rsp_valid) pulses++;
    end
    a_valid = 1'b0; a_write = 1'b0;
    tick();
    if (a_rsp_valid) pulses++;
    check("t2_rsp_pulses", 32'(pulses), 32'd16);
    check("t2_ready_low", 32'(ready_low), 32'd0);
    check("t2_writes_count", a_wc, STATS ? 32'd16 : 32'd0);
    tick();
    check("t2_idle_rsp", 32'(a_rsp_valid), 32'd0);
    for (int i = 0; i < 16; i++) a_read_op(12'(i), 16'(i * 3), 1'b0, "t2_rd");
    check("t2_reads_count", a_rc, STATS ? 32'd16 : 32'd0);

    // Out-of-range write and read at addr 100 with DEPTH=64
    a_write_op(12'd36, 16'h0123, 1'b0, "t3_w36");
    a_write_op(12'd100, 16'd5, 1'b1, "t3_w100");
    a_read_op(12'd100, 16'd0, 1'b1, "t3_r100");
    check("t3_err_count", a_ec, STATS ? 32'd2 : 32'd0);
    a_read_op(12'd36, 16'h0123, 1'b0, "t3_r36");

    // Backpressure on dut_b (RD_LAT=3)
    b_valid = 1'b1; b_write = 1'b1; b_addr = 12'd5; b_wdata = 16'd9;
    tick();
    b_addr = 12'd6; b_wdata = 16'h1234;
    tick();
    check("t4_w5_rsp", 32'(b_rsp_valid), 32'd1);
    b_valid = 1'b0; b_write = 1'b0;
    tick();
    check("t4_w6_rsp", 32'(b_rsp_valid), 32'd1);
    b_valid = 1'b1; b_addr = 12'd5;
    check("t4_ready_idle", 32'(b_ready), 32'd1);
    tick();
    b_addr = 12'd6;
    check("t4_ready_wait1", 32'(b_ready), 32'd0);
    tick();
    check("t4_ready_wait2", 32'(b_ready), 32'd0);
    tick();
    check("t4_ready_resp", 32'(b_ready), 32'd1);
    check("t4_rsp_early", 32'(b_rsp_valid), 32'd0);
    tick();
    check("t4_rsp1_valid", 32'(b_rsp_valid), 32'd1);
    check("t4_rsp1_rdata", 32'(b_rdata), 32'd9);
    b_valid = 1'b0;
    check("t4_second_accepted", 32'(b_ready), 32'd0);
    pulses = 0;
    tick(); if (b_rsp_valid) pulses++;
    tick(); if (b_rsp_valid) pulses++;
    check("t4_gap", 32'(pulses), 32'd0);
    tick();
    check("t4_rsp2_valid", 32'(b_rsp_valid), 32'd1);
    check("t4_rsp2_rdata", 32'(b_rdata), 32'h1234);
    check("t4_rsp2_err", 32'(b_err), 32'd0);
    check("t4_reads_count", b_rc, STATS ? 32'd2 : 32'd0);
    check("t4_writes_count", b_wc, STATS ? 32'd2 : 32'd0);
    tick();

    // Reset one cycle after a read is accepted
    a_valid = 1'b1; a_write = 1'b0; a_addr = 12'd3;
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_rsp_valid) stray++;
    end
    check("t5_no_stray_rsp", 32'(stray), 32'd0);
    check("t5_ready", 32'(a_ready), 32'd1);
    check("t5_a_counts", a_rc | a_wc | a_ec, 32'd0);
    check("t5_b_counts", b_rc | b_wc | b_ec, 32'd0);

    // Reset dominates a same-cycle write to addr 7
    rst = 1'b1;
    a_valid = 1'b1; a_write = 1'b1; a_addr = 12'd7; a_wdata = 16'h0055;
    tick();
    rst = 1'b0;
    a_valid = 1'b0; a_write = 1'b0;
    tick();
    check("t5_rst_wr_no_rsp", 32'(a_rsp_valid), 32'd0);
    a_read_op(12'd3, 16'd9, 1'b0, "t5_r3");
    a_read_op(12'd7, 16'd21, 1'b0, "t5_r7");
    a_read_op(12'd16, 16'hFFF9, 1'b0, "t5_r16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_mem_responder.md
Name: npu_mem_responder

Overview:
- Memory-side responder for the systolic NPU's single-port request interface. The engine is the initiator: it drives the address, the write strobe and the write data, and reads data back.
- Owns a word-addressed scratchpad holding the A, B and C matrices. Serves one outstanding request at a time, with a configurable read latency and a ready/valid handshake.
- Replaces the behavioural memory model in the benches and becomes the synthesizable scratchpad in the top level.

Parameters:
- WIDTH, 16, data word width (signed two's complement, matches the engine).
- ADDR_W, 12, request address width.
- DEPTH, 4096, number of implemented words. Must be ≤ 2**ADDR_W.
- RD_LAT, 2, cycles from read acceptance to response. Must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  initiator has a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WIDTH  read data. 0 for writes and errors.
- rsp_err  out  1  address out of range; qualified by rsp_valid.
- reads_count  out  32  accepted reads (statistics).
- writes_count  out  32  accepted writes (statistics).
- err_count  out  32  out-of-range requests (statistics).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- States (mem_state_t): MEM_IDLE, MEM_WAIT, MEM_RESP.
- req_ready = (state == MEM_IDLE) || (state == MEM_RESP). It is combinational from state only and never depends on req_valid.
- A request is accepted at a rising edge where req_valid && req_ready. req_* fields are captured at that edge.
- Write acceptance:
  - Memory is updated at the same edge.
  - Next state is MEM_RESP: rsp_valid=1, rsp_rdata=0, rsp_err=0 for exactly one cycle.
  - Sustained throughput is one write per cycle.
- Read acceptance:
  - Next state is MEM_WAIT with latency counter = RD_LAT-1. If RD_LAT==1, next state is MEM_RESP directly.
  - In MEM_WAIT the counter decrements each cycle; at 1 the next state is MEM_RESP.
  - rsp_valid is registered high at edge t0+RD_LAT, where t0 is the acceptance edge.
  - Throughput is one read per RD_LAT cycles.
- MEM_RESP: if a new request is accepted, go to the state implied by that request; otherwise go to MEM_IDLE.
- Read-after-write: a read accepted at the edge after a write to the same address returns the new data.
- Out of range (req_addr ≥ DEPTH):
  - Write is suppressed.
  - Read returns rsp_rdata=0.
  - rsp_err=1 with normal latency (1 cycle for a write, RD_LAT for a read).
  - err_count increments.
- req_valid held with req_ready=0: no effect. The initiator must hold the request stable until it is accepted.
- Reset:
  - state=MEM_IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; all counters=0.
  - An in-flight read is dropped and never responded to.
  - Memory contents are not cleared.
  - rst dominates any same-cycle request: no write occurs.
- Counters increment on acceptance and wrap at 2**32.

Optional Feature:
- Macro: NPU_MEM_STATS_EN.
- Defined: reads_count, writes_count and err_count are live as specified above.
- Undefined: the counter registers are not instantiated, the ports remain present and are tied to 32'd0, and all other behaviour is unchanged.

Decomposition:
- SystolicTypes package gains:
  - mem_state_t enum {MEM_IDLE, MEM_WAIT, MEM_RESP}.
  - localparam MEM_CNT_W = 32.
- Sub-module npu_mem_array:
  - DEPTH x WIDTH storage.
  - Synchronous write; registered read feeding a RD_LAT-1 deep pipeline.
  - No reset on data.
- npu_mem_responder holds the FSM, latency counter, range check and statistics.

Test Plan:
- Write-then-read, RD_LAT=2: write addr 16 data -7, then read addr 16. Expect:
  - rsp_valid one cycle after the write acceptance.
  - Read rsp_rdata=-7 exactly 2 cycles after read acceptance, rsp_err=0.
- Back-to-back writes: req_valid held, addresses 0..15, data i*3. Expect:
  - req_ready constantly 1 and 16 consecutive rsp_valid pulses.
  - Reading back addresses 0..15 returns 0,3,...,45.
  - writes_count=16 (with the macro defined).
- Backpressure, RD_LAT=3: read addr 5 (value 9) with a second read addr 6 queued. Expect:
  - req_ready=0 for 2 cycles after the first acceptance.
  - Second request accepted in the MEM_RESP cycle.
  - Responses 9 then the addr-6 value, 3 cycles apart.
- Out of range, DEPTH=64: write addr 100 data 5, then read addr 100. Expect:
  - Both responses have rsp_err=1; read rsp_rdata=0.
  - err_count=2.
  - Memory at addr 36 (=100 mod 64) unchanged.
- Reset mid-read: accept a read, assert rst one cycle later. Expect:
  - No rsp_valid is ever produced for that read.
  - req_ready=1 after reset; counters 0.
  - Previously written data is still readable.
- Stats compiled out: rerun the back-to-back-writes scenario without NPU_MEM_STATS_EN. Expect identical responses; all three count ports read 0.
